// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt sequencer owning mstatus, mie, mtvec, mip, mepc, mcause
module trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ext_irq,
   input  logic        tmr_irq,
   input  logic        sw_irq,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic        mret_valid,
   input  logic        commit_valid,
   input  logic [31:0] commit_next_pc,
   input  logic        pipe_empty,
   input  logic [31:0] fetch_pc,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        fetch_stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] mstatus,
   output logic [31:0] mie,
   output logic [31:0] mtvec,
   output logic [31:0] mip,
   output logic [31:0] mepc,
   output logic [31:0] mcause
);
   typedef enum logic [1:0] {IDLE, DRAIN, ENTER, RETURN} state_t;
   state_t state, state_n;
   logic mie_b, mpie;
   logic [31:0] mie_q, mtvec_q, mip_q, mepc_q, mcause_q;
   logic [31:0] cause_q, epc_q, cause_n, epc_n;
   logic [31:0] pending, trap_pc;
   logic [3:0] irq_code;
   logic vec;
   assign mstatus = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_b, 3'b0};
   assign mie = mie_q;
   assign mtvec = mtvec_q;
   assign mip = mip_q;
   assign mepc = mepc_q;
   assign mcause = mcause_q;
   assign pending = mip_q & mie_q & {32{mie_b}};
   assign irq_code = pending[11] ? 4'd11 : pending[3] ? 4'd3 : 4'd7;
   assign vec = VECTORED_EN && mtvec_q[0] && cause_q[31];
   assign trap_pc = {mtvec_q[31:2], 2'b00} + (vec ? {26'b0, cause_q[3:0], 2'b00} : 32'b0);
   assign csr_rdata = csr_addr == 12'h300 ? mstatus :
                      csr_addr == 12'h304 ? mie_q :
                      csr_addr == 12'h305 ? mtvec_q :
                      csr_addr == 12'h341 ? mepc_q :
                      csr_addr == 12'h342 ? mcause_q :
                      csr_addr == 12'h344 ? mip_q : 32'b0;
   // sequencer state plus the trap cause/PC captured on the way into ENTER
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         cause_q <= 32'b0;
         epc_q <= 32'b0;
      end else begin
         state <= state_n;
         cause_q <= cause_n;
         epc_q <= epc_n;
      end
   end
   // next state, trap latch and pipeline control; interrupts wait in DRAIN for a precise PC
   always_comb begin
      state_n = state;
      cause_n = cause_q;
      epc_n = epc_q;
      fetch_stall = 1'b0;
      flush = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'b0;
      case (state)
         IDLE: begin
            if (exc_valid) begin
               cause_n = {28'b0, exc_cause};
               epc_n = exc_pc;
               state_n = ENTER;
            end else if (mret_valid) state_n = RETURN;
            else if (|pending) state_n = DRAIN;
         end
         DRAIN: begin
            fetch_stall = 1'b1;
            if (exc_valid) begin
               cause_n = {28'b0, exc_cause};
               epc_n = exc_pc;
               state_n = ENTER;
            end else if (pending == 32'b0) state_n = IDLE;
            else if (commit_valid || pipe_empty) begin
               cause_n = {1'b1, 27'b0, irq_code};
               epc_n = commit_valid ? commit_next_pc : fetch_pc;
               state_n = ENTER;
            end
         end
         ENTER: begin
            fetch_stall = 1'b1;
            flush = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = trap_pc;
            state_n = IDLE;
         end
         RETURN: begin
            flush = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc = mepc_q;
            state_n = IDLE;
         end
      endcase
   end
   // CSR file: trap entry/return updates take precedence over software writes to the same CSRs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mie_b <= 1'b0;
         mpie <= 1'b0;
         mie_q <= 32'b0;
         mtvec_q <= RESET_MTVEC;
         mip_q <= 32'b0;
         mepc_q <= 32'b0;
         mcause_q <= 32'b0;
      end else begin
         mip_q <= {20'b0, ext_irq, 3'b0, tmr_irq, 3'b0, sw_irq, 3'b0};
         if (csr_we && csr_addr == 12'h304) mie_q <= csr_wdata & 32'h0000_0888;
         if (csr_we && csr_addr == 12'h305) mtvec_q <= csr_wdata & ~32'h2;
         if (state == ENTER) begin
            mepc_q <= epc_q;
            mcause_q <= cause_q;
            mpie <= mie_b;
            mie_b <= 1'b0;
         end else begin
            if (csr_we && csr_addr == 12'h341) mepc_q <= csr_wdata & ~32'h3;
            if (csr_we && csr_addr == 12'h342) mcause_q <= csr_wdata;
            if (state == RETURN) begin
               mie_b <= mpie;
               mpie <= 1'b1;
            end else if (csr_we && csr_addr == 12'h300) begin
               mie_b <= csr_wdata[3];
               mpie <= csr_wdata[7];
            end
         end
      end
   end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed trap scenarios plus random traffic checked against a behavioural model
module tb_trap_ctrl;
   localparam logic [31:0] RST_TV = 32'h0000_0200;
   logic clk = 1'b0, rstn = 1'b0;
   logic ext_irq = 1'b0, tmr_irq = 1'b0, sw_irq = 1'b0;
   logic exc_valid = 1'b0, mret_valid = 1'b0, commit_valid = 1'b0, pipe_empty = 1'b0, csr_we = 1'b0;
   logic [3:0] exc_cause = 4'b0;
   logic [11:0] csr_addr = 12'b0;
   logic [31:0] exc_pc = 32'b0, commit_next_pc = 32'b0, fetch_pc = 32'b0, csr_wdata = 32'b0;
   logic [31:0] csr_rdata, redirect_pc, mstatus, mie, mtvec, mip, mepc, mcause;
   logic fetch_stall, flush, redirect_valid;
   int n_chk = 0, n_err = 0;
   // model: st 0=idle 1=drain 2=enter 3=return
   int m_st = 0;
   bit m_ok = 1'b0;
   logic m_ie = 1'b0, m_pie = 1'b0;
   logic [31:0] m_mie = 0, m_tvec = 0, m_mip = 0, m_epcr = 0, m_causer = 0, m_cause = 0, m_epc = 0;
   trap_ctrl #(.RESET_MTVEC(RST_TV), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rstn(rstn), .ext_irq(ext_irq), .tmr_irq(tmr_irq), .sw_irq(sw_irq),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .mret_valid(mret_valid),
      .commit_valid(commit_valid), .commit_next_pc(commit_next_pc), .pipe_empty(pipe_empty),
      .fetch_pc(fetch_pc), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .fetch_stall(fetch_stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus(mstatus), .mie(mie),
      .mtvec(mtvec), .mip(mip), .mepc(mepc), .mcause(mcause)
   );
   // free-running clock
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   function automatic logic [31:0] m_status();
      return 32'h1800 | (m_pie ? 32'h80 : 32'h0) | (m_ie ? 32'h8 : 32'h0);
   endfunction
   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_status();
         12'h304: return m_mie;
         12'h305: return m_tvec;
         12'h341: return m_epcr;
         12'h342: return m_causer;
         12'h344: return m_mip;
         default: return 32'h0;
      endcase
   endfunction
   function automatic logic [31:0] m_redirect();
      logic [31:0] t;
      if (m_st == 3) return m_epcr;
      if (m_st != 2) return 32'h0;
      t = m_tvec & ~32'h3;
      if (m_tvec[0] && m_cause[31]) t = t + 4 * m_cause[3:0];
      return t;
   endfunction
   task automatic model_update();
      logic [31:0] pend, nepcr, ncauser;
      logic nie, npie;
      int code, nst;
      if (!rstn) begin
         m_st = 0; m_ie = 0; m_pie = 0; m_mie = 0; m_tvec = RST_TV; m_mip = 0; m_epcr = 0; m_causer = 0;
         m_ok = 1'b1;
         return;
      end
      pend = m_ie ? (m_mip & m_mie) : 32'h0;
      code = pend[11] ? 11 : (pend[3] ? 3 : 7);
      nie = m_ie; npie = m_pie; nepcr = m_epcr; ncauser = m_causer; nst = m_st;
      if (csr_we) begin
         if (csr_addr == 12'h300 && m_st < 2) begin nie = csr_wdata[3]; npie = csr_wdata[7]; end
         if (csr_addr == 12'h304) m_mie = csr_wdata & 32'h888;
         if (csr_addr == 12'h305) m_tvec = csr_wdata & ~32'h2;
         if (csr_addr == 12'h341 && m_st != 2) nepcr = csr_wdata & ~32'h3;
         if (csr_addr == 12'h342 && m_st != 2) ncauser = csr_wdata;
      end
      if (m_st < 2 && exc_valid) begin
         m_cause = {28'h0, exc_cause}; m_epc = exc_pc; nst = 2;
      end else if (m_st == 0) begin
         if (mret_valid) nst = 3;
         else if (pend != 0) nst = 1;
      end else if (m_st == 1) begin
         if (pend == 0) nst = 0;
         else if (commit_valid || pipe_empty) begin
            m_epc = commit_valid ? commit_next_pc : fetch_pc;
            m_cause = 32'h8000_0000 | code;
            nst = 2;
         end
      end else if (m_st == 2) begin
         nepcr = m_epc; ncauser = m_cause; npie = m_ie; nie = 0; nst = 0;
      end else begin
         nie = m_pie; npie = 1; nst = 0;
      end
      m_ie = nie; m_pie = npie; m_epcr = nepcr; m_causer = ncauser; m_st = nst;
      m_mip = (ext_irq ? 32'h800 : 0) | (tmr_irq ? 32'h80 : 0) | (sw_irq ? 32'h8 : 0);
   endtask
   task automatic step();
      #1;
      if (m_ok) begin
         check("fetch_stall", 32'(fetch_stall), 32'(m_st == 1 || m_st == 2));
         check("flush", 32'(flush), 32'(m_st >= 2));
         check("redirect_valid", 32'(redirect_valid), 32'(m_st >= 2));
         check("redirect_pc", redirect_pc, m_redirect());
         check("csr_rdata", csr_rdata, m_read(csr_addr));
         check("mstatus", mstatus, m_status());
         check("mie", mie, m_mie);
         check("mtvec", mtvec, m_tvec);
         check("mip", mip, m_mip);
         check("mepc", mepc, m_epcr);
         check("mcause", mcause, m_causer);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask
   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      step();
      csr_we = 1'b0;
   endtask
   // directed scenarios followed by random traffic with occasional resets
   initial begin
      logic [11:0] addrs [7];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
      @(negedge clk);
      step(); step();
      rstn = 1'b1;
      check("rst_mstatus", mstatus, 32'h1800);
      check("rst_mie", mie, 32'h0);
      check("rst_mtvec", mtvec, RST_TV);
      check("rst_mip", mip, 32'h0);
      check("rst_mepc", mepc, 32'h0);
      check("rst_mcause", mcause, 32'h0);
      check("rst_ctrl", {fetch_stall, flush, redirect_valid}, 32'h0);
      check("rst_redirect_pc", redirect_pc, 32'h0);
      csr_wr(12'h305, 32'h100); csr_wr(12'h300, 32'h8); csr_wr(12'h304, 32'h800);
      ext_irq = 1'b1; step(); step();
      check("ext_drain_stall", 32'(fetch_stall), 32'h1);
      commit_valid = 1'b1; commit_next_pc = 32'h40; step();
      commit_valid = 1'b0; ext_irq = 1'b0;
      check("ext_redirect_pc", redirect_pc, 32'h100);
      check("ext_flush", 32'(flush), 32'h1);
      step();
      check("ext_mepc", mepc, 32'h40);
      check("ext_mcause", mcause, 32'h8000_000B);
      check("ext_mstatus", mstatus, 32'h1880);
      mret_valid = 1'b1; step(); mret_valid = 1'b0;
      check("mret_redirect_pc", redirect_pc, 32'h40);
      check("mret_redirect_valid", 32'(redirect_valid), 32'h1);
      step();
      check("mret_mstatus", mstatus, 32'h1888);
      csr_wr(12'h305, 32'h101);
      tmr_irq = 1'b1; pipe_empty = 1'b1; fetch_pc = 32'h20;
      csr_wr(12'h304, 32'h80);
      step(); step();
      check("tmr_vec_redirect_pc", redirect_pc, 32'h11C);
      tmr_irq = 1'b0; pipe_empty = 1'b0;
      step();
      check("tmr_mepc", mepc, 32'h20);
      check("tmr_mcause", mcause, 32'h8000_0007);
      csr_wr(12'h305, 32'h100); csr_wr(12'h300, 32'h8);
      ext_irq = 1'b1; csr_wr(12'h304, 32'h800);
      step();
      check("exc_drain_stall", 32'(fetch_stall), 32'h1);
      exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h30; commit_valid = 1'b1; commit_next_pc = 32'h44;
      step();
      exc_valid = 1'b0; commit_valid = 1'b0; ext_irq = 1'b0;
      check("exc_redirect_pc", redirect_pc, 32'h100);
      step();
      check("exc_mcause", mcause, 32'h2);
      check("exc_mepc", mepc, 32'h30);
      csr_wr(12'h300, 32'h8);
      sw_irq = 1'b1; csr_wr(12'h304, 32'h8);
      step();
      check("wd_drain_stall", 32'(fetch_stall), 32'h1);
      csr_wr(12'h304, 32'h0);
      step();
      sw_irq = 1'b0;
      check("wd_stall", 32'(fetch_stall), 32'h0);
      check("wd_flush", 32'(flush), 32'h0);
      check("wd_mepc", mepc, 32'h30);
      step();
      csr_wr(12'h344, 32'hFFFF_FFFF);
      check("mip_ro", mip, 32'h0);
      check("mip_read", csr_rdata, 32'h0);
      csr_addr = 12'h123; #1;
      check("unmapped_read", csr_rdata, 32'h0);
      csr_addr = 12'h305; #1;
      check("mtvec_read", csr_rdata, 32'h100);
      for (int i = 0; i < 3000; i++) begin
         rstn = $urandom_range(0, 299) != 0;
         if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
         if ($urandom_range(0, 15) == 0) tmr_irq = ~tmr_irq;
         if ($urandom_range(0, 15) == 0) sw_irq = ~sw_irq;
         exc_valid = $urandom_range(0, 19) == 0;
         exc_cause = 4'($urandom);
         exc_pc = $urandom;
         mret_valid = $urandom_range(0, 24) == 0;
         commit_valid = $urandom_range(0, 3) == 0;
         commit_next_pc = $urandom;
         pipe_empty = $urandom_range(0, 5) == 0;
         fetch_pc = $urandom;
         csr_we = $urandom_range(0, 3) == 0;
         csr_addr = addrs[$urandom_range(0, 6)];
         csr_wdata = $urandom;
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
